// File: rtl/branch_seq_uc.sv
// ============================================================================
// branch_seq_uc - conditional-branch sequencer for the multicycle control unit.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken counters. Rev 1.0
// ============================================================================
`default_nettype none

module branch_seq_uc #(
  parameter int CMP_LAT = 1
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       branch_taken,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [2:0] alu_op,
  output logic       aluout_write,
  output logic       UC_control,
  output logic [1:0] UC_op,
  output logic       pc_write,
  output logic [1:0] pc_source
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
`endif
);

  localparam int             LAT_W    = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CMP_LAT - 1);

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TARGET   = 3'd1,
    S_COMPARE  = 3'd2,
    S_WRITE_PC = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] cmp_cnt;
  logic             sample;
  logic             is_branch;

  // branch_taken is only meaningful on the edge closing the last COMPARE cycle
  assign sample    = (state == S_COMPARE) && (cmp_cnt == LAT_LAST);
  assign is_branch = (opcode[5:2] == 4'b0001);

  // Outputs are registered from the next state, so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cmp_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      alu_srca     <= 1'b0;
      alu_srcb     <= 2'b00;
      alu_op       <= ALU_IDLE;
      aluout_write <= 1'b0;
      UC_control   <= 1'b0;
      UC_op        <= 2'b00;
      pc_write     <= 1'b0;
      pc_source    <= 2'b00;
    end else begin
      done         <= 1'b0;
      illegal      <= 1'b0;
      alu_srca     <= 1'b0;
      alu_srcb     <= 2'b00;
      alu_op       <= ALU_IDLE;
      aluout_write <= 1'b0;
      UC_control   <= 1'b0;
      pc_write     <= 1'b0;
      pc_source    <= 2'b00;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (is_branch) begin
              state        <= S_TARGET;
              busy         <= 1'b1;
              UC_op        <= opcode[1:0];
              alu_srcb     <= 2'b11;
              alu_op       <= ALU_ADD;
              aluout_write <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end

        S_TARGET: begin
          state      <= S_COMPARE;
          cmp_cnt    <= '0;
          alu_srca   <= 1'b1;
          alu_op     <= ALU_SUB;
          UC_control <= 1'b1;
        end

        S_COMPARE: begin
          if (sample) begin
            if (branch_taken) begin
              state     <= S_WRITE_PC;
              pc_write  <= 1'b1;
              pc_source <= 2'b01;
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
            end
          end else begin
            cmp_cnt    <= cmp_cnt + LAT_W'(1);
            alu_srca   <= 1'b1;
            alu_op     <= ALU_SUB;
            UC_control <= 1'b1;
          end
        end

        S_WRITE_PC: begin
          state <= S_FINISH;
          done  <= 1'b1;
        end

        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (sample) begin
      if (branch_taken) begin
        if (taken_cnt != '1)
          taken_cnt <= taken_cnt + CNT_W'(1);
      end else begin
        if (not_taken_cnt != '1)
          not_taken_cnt <= not_taken_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_seq_uc.sv
// ============================================================================
// tb_branch_seq_uc - bench for branch_seq_uc with CMP_LAT=1 and CMP_LAT=3 copies
// sharing one stimulus stream, each tracked by an elapsed-cycle model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_seq_uc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       branch_taken = 1'b0;

  logic       busy1, done1, ill1, srca1, aw1, ucc1, pcw1;
  logic [1:0] srcb1, ucop1, pcs1;
  logic [2:0] op1;
  logic       busy3, done3, ill3, srca3, aw3, ucc3, pcw3;
  logic [1:0] srcb3, ucop3, pcs3;
  logic [2:0] op3;
`ifdef BRANCH_STATS_EN
  logic [15:0] tc1, nc1;
  logic [1:0]  tc3, nc3;
`endif

  always #5 clk = ~clk;

  branch_seq_uc #(.CMP_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch_taken(branch_taken),
    .busy(busy1), .done(done1), .illegal(ill1), .alu_srca(srca1), .alu_srcb(srcb1),
    .alu_op(op1), .aluout_write(aw1), .UC_control(ucc1), .UC_op(ucop1),
    .pc_write(pcw1), .pc_source(pcs1)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc1), .not_taken_cnt(nc1)
`endif
  );

  branch_seq_uc #(.CMP_LAT(3)
`ifdef BRANCH_STATS_EN
    , .CNT_W(2)
`endif
  ) u3 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch_taken(branch_taken),
    .busy(busy3), .done(done3), .illegal(ill3), .alu_srca(srca3), .alu_srcb(srcb3),
    .alu_op(op3), .aluout_write(aw3), .UC_control(ucc3), .UC_op(ucop3),
    .pc_write(pcw3), .pc_source(pcs3)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc3), .not_taken_cnt(nc3)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  // Model: a branch accepted at edge A shows TARGET after A, COMPARE after
  // A+1..A+L, samples branch_taken at A+L+1, then WRITE_PC (if taken), FINISH.
  int         cyc = 0;
  int         m_acc[2], m_end[2], m_ill[2], m_tc[2], m_nc[2];
  bit         m_dec[2], m_tk[2];
  logic [1:0] m_ucop[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = -1; m_end[i] = 0; m_ill[i] = -1; m_tc[i] = 0; m_nc[i] = 0;
        m_dec[i] = 1'b0; m_tk[i] = 1'b0; m_ucop[i] = 2'b00;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i] >= 0 && !m_dec[i] && cyc == m_acc[i] + lat(i) + 1) begin
          m_dec[i] = 1'b1;
          m_tk[i]  = branch_taken;
          m_end[i] = cyc + 1 + int'(branch_taken);
          if (branch_taken) m_tc[i] = (m_tc[i] < cmax(i)) ? m_tc[i] + 1 : m_tc[i];
          else              m_nc[i] = (m_nc[i] < cmax(i)) ? m_nc[i] + 1 : m_nc[i];
        end
        if ((m_acc[i] < 0 || (m_dec[i] && cyc > m_end[i])) && start) begin
          if (opcode >= 6'h04 && opcode <= 6'h07) begin
            m_acc[i]  = cyc;
            m_dec[i]  = 1'b0;
            m_ucop[i] = opcode[1:0];
          end else begin
            m_ill[i] = cyc;
          end
        end
      end
    end
  end

  function automatic logic [15:0] model_out(input int i);
    int L, k;
    bit act, is_t, is_c, is_w, is_f;
    L    = lat(i);
    act  = (m_acc[i] >= 0) && !(m_dec[i] && cyc >= m_end[i]);
    k    = cyc - m_acc[i];
    is_t = act && (k == 0);
    is_c = act && (k >= 1) && (k <= L);
    is_w = act && m_dec[i] && m_tk[i] && (k == L + 1);
    is_f = act && m_dec[i] && (k == L + 1 + int'(m_tk[i]));
    return {act, is_f, (m_ill[i] == cyc), is_c,
            is_t ? 2'b11 : 2'b00,
            is_t ? 3'b001 : (is_c ? 3'b010 : 3'b000),
            is_t, is_c, m_ucop[i], is_w, is_w ? 2'b01 : 2'b00};
  endfunction

  logic [15:0] vec1, vec3;
  assign vec1 = {busy1, done1, ill1, srca1, srcb1, op1, aw1, ucc1, ucop1, pcw1, pcs1};
  assign vec3 = {busy3, done3, ill3, srca3, srcb3, op3, aw3, ucc3, ucop3, pcw3, pcs3};

  always @(negedge clk) begin
    if (chk_on) begin
      check("u1 outputs vs model", vec1, model_out(0));
      check("u3 outputs vs model", vec3, model_out(1));
      check("u1 pc_write&done", 16'(pcw1 & done1), 16'h0);
      check("u3 pc_write&done", 16'(pcw3 & done3), 16'h0);
`ifdef BRANCH_STATS_EN
      check("u1 taken_cnt", tc1, 16'(m_tc[0]));
      check("u1 not_taken_cnt", nc1, 16'(m_nc[0]));
      check("u3 taken_cnt", 16'(tc3), 16'(m_tc[1]));
      check("u3 not_taken_cnt", 16'(nc3), 16'(m_nc[1]));
`endif
    end
  end

  typedef struct {
    logic [5:0] op;
    logic       tk;
    logic [1:0] ucop;
    logic       ill;
    logic       pcw;
    int         lat1;
    int         lat3;
  } vec_t;

  vec_t tbl[8];

  task automatic run_op(input logic [5:0] op, input logic tk);
    opcode = op; branch_taken = tk; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    tbl[0] = '{6'h04, 1'b1, 2'd0, 1'b0, 1'b1, 4, 6};
    tbl[1] = '{6'h07, 1'b0, 2'd3, 1'b0, 1'b0, 3, 5};
    tbl[2] = '{6'h23, 1'b1, 2'd3, 1'b1, 1'b0, 0, 0};
    tbl[3] = '{6'h05, 1'b1, 2'd1, 1'b0, 1'b1, 4, 6};
    tbl[4] = '{6'h03, 1'b0, 2'd1, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{6'h06, 1'b1, 2'd2, 1'b0, 1'b1, 4, 6};
    tbl[6] = '{6'h08, 1'b1, 2'd2, 1'b1, 1'b0, 0, 0};
    tbl[7] = '{6'h06, 1'b0, 2'd2, 1'b0, 1'b0, 3, 5};

    repeat (2) tick();
    check("reset state u1", vec1, 16'h0);
    check("reset state u3", vec3, 16'h0);
    reset  = 1'b0;
    chk_on = 1'b1;
    tick();

    // Table vectors: one branch per entry, latency counted in edges from the drive edge
    for (int v = 0; v < 8; v++) begin
      int l1, l3;
      bit pw1, pw3, il1, bz;
      l1 = 0; l3 = 0; pw1 = 0; pw3 = 0; il1 = 0; bz = 0;
      opcode = tbl[v].op; branch_taken = tbl[v].tk; start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (k == 1) begin
          start = 1'b0;
          il1   = ill1;
        end
        if (done1 && l1 == 0) l1 = k;
        if (done3 && l3 == 0) l3 = k;
        pw1 |= pcw1;
        pw3 |= pcw3;
        bz  |= busy1 | busy3;
      end
      check("tbl illegal", 16'(il1), 16'(tbl[v].ill));
      check("tbl busy seen", 16'(bz), 16'(!tbl[v].ill));
      check("tbl pc_write u1", 16'(pw1), 16'(tbl[v].pcw));
      check("tbl pc_write u3", 16'(pw3), 16'(tbl[v].pcw));
      check("tbl done latency u1", 16'(l1), 16'(tbl[v].lat1));
      check("tbl done latency u3", 16'(l3), 16'(tbl[v].lat3));
      check("tbl UC_op u1", 16'(ucop1), 16'(tbl[v].ucop));
      check("tbl UC_op u3", 16'(ucop3), 16'(tbl[v].ucop));
    end

`ifdef BRANCH_STATS_EN
    check("stats u1 taken=3", tc1, 16'd3);
    check("stats u1 not_taken=2", nc1, 16'd2);
    check("stats u3 taken=3", 16'(tc3), 16'd3);
    check("stats u3 not_taken=2", 16'(nc3), 16'd2);
`endif
    run_op(6'h04, 1'b1);
    run_op(6'h07, 1'b1);
`ifdef BRANCH_STATS_EN
    check("stats u1 taken=5", tc1, 16'd5);
    check("stats u3 taken saturated", 16'(tc3), 16'd3);
`endif

    // BNE on CMP_LAT=3: taken high on early COMPARE cycles, low at the sampling edge
    opcode = 6'h05; branch_taken = 1'b1; start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    branch_taken = 1'b0;
    check("T5 UC_control last compare", 16'(ucc3), 16'h1);
    check("T5 UC_op BNE", 16'(ucop3), 16'h1);
    tick();
    check("T5 done not taken", 16'(done3), 16'h1);
    check("T5 no pc_write", 16'(pcw3), 16'h0);
    tick();
    check("T5 idle after done", 16'(busy3), 16'h0);
    tick();
    check("T5 re-accept held start", 16'(aw3 & busy3), 16'h1);
    start = 1'b0;
    repeat (10) tick();

    // Reset in the middle of COMPARE on u3 (u1 is in WRITE_PC at that point)
    opcode = 6'h04; branch_taken = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("T1 u3 in compare", 16'(ucc3), 16'h1);
    reset = 1'b1;
    #1;
    check("T1 u1 outputs cleared", vec1, 16'h0);
    check("T1 u3 outputs cleared", vec3, 16'h0);
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("T1 idle after release", 16'(busy3 | busy1), 16'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      start        = (($urandom % 3) == 0);
      opcode       = (($urandom % 4) == 0) ? 6'($urandom) : 6'(4 + ($urandom % 4));
      branch_taken = 1'($urandom % 2);
      if (($urandom % 250) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    repeat (12) tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
